// File: rtl/one_hot_mux_pipe.sv
// one_hot_mux_pipe: one-hot select mux with per-channel valid/ready, one registered output stage and select-error status.
// Define ONE_HOT_MUX_PIPE_ZERO_SEL_ERR_EN to also flag an all-zero select with pending input valid as an error.
module one_hot_mux_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT   = 5,
  parameter int ECW   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH*CNT-1:0] in_data,
  input  logic [CNT-1:0]       in_valid,
  output logic [CNT-1:0]       in_ready,
  input  logic [CNT-1:0]       sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 err,
  output logic                 err_sticky,
  output logic [ECW-1:0]       err_cnt,
  input  logic                 err_clr
);
  localparam logic [CNT-1:0] ONE = CNT'(1);
  logic             sel_zero, sel_one, sel_multi, buf_rdy, xfer, err_ev;
  logic [WIDTH-1:0] mux_data;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d, err_q, err_d, sticky_q, sticky_d;
  logic [ECW-1:0]   cnt_q, cnt_d;
  assign sel_zero  = sel == '0;
  assign sel_one   = !sel_zero && ((sel & (sel - ONE)) == '0);
  assign sel_multi = !sel_zero && !sel_one;
  assign buf_rdy   = !out_valid_q || out_ready;
  assign in_ready  = (sel_one && buf_rdy) ? sel : '0;
  assign xfer      = |(in_valid & in_ready);
`ifdef ONE_HOT_MUX_PIPE_ZERO_SEL_ERR_EN
  assign err_ev    = |in_valid && (sel_multi || sel_zero);
`else
  assign err_ev    = |in_valid && sel_multi;
`endif
  // Indexed pick rather than AND-OR so no other channel's bits can leak in.
  always_comb begin
    mux_data = '0;
    for (int k = 0; k < CNT; k++)
      if (sel[k]) mux_data = in_data[k*WIDTH +: WIDTH];
  end
  always_comb begin
    out_valid_d = buf_rdy ? xfer : 1'b1;
    out_data_d  = xfer ? mux_data : out_data_q;
    err_d       = err_ev;
    sticky_d    = err_clr ? 1'b0 : (sticky_q || err_ev);
    cnt_d       = err_clr ? '0 : (err_ev && !(&cnt_q)) ? cnt_q + ECW'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
    end
  end
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign err        = err_q;
  assign err_sticky = sticky_q;
  assign err_cnt    = cnt_q;
endmodule

// File: tb/tb_one_hot_mux_pipe.sv
// tb_one_hot_mux_pipe: directed-vector bench for one_hot_mux_pipe (WIDTH=32, CNT=5, ECW=2).
module tb_one_hot_mux_pipe;
  localparam int W = 32, C = 5, E = 2;
`ifdef ONE_HOT_MUX_PIPE_ZERO_SEL_ERR_EN
  localparam bit ZERR = 1'b1;
`else
  localparam bit ZERR = 1'b0;
`endif
  logic           clk = 0, rst_n = 0, out_ready = 0, err_clr = 0;
  logic [W*C-1:0] in_data = '0;
  logic [C-1:0]   in_valid = '0, sel = '0, in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid, err, err_sticky;
  logic [E-1:0]   err_cnt;
  int             n_chk = 0, n_fail = 0;
  one_hot_mux_pipe #(.WIDTH(W), .CNT(C), .ECW(E)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .err(err), .err_sticky(err_sticky), .err_cnt(err_cnt), .err_clr(err_clr)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_ch(input int k, input logic [W-1:0] d);
    in_data[k*W +: W] = d;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_err", err, 0);
    check("rst_sticky", err_sticky, 0);
    check("rst_cnt", err_cnt, 0);
    @(negedge clk) rst_n = 1;
    tick();
    // single transfer
    sel = 5'b00100; in_valid = 5'b00100; set_ch(2, 32'hDEADBEEF); out_ready = 1;
    #1 check("t1_ready", in_ready, 5'b00100);
    tick();
    check("t1_valid", out_valid, 1);
    check("t1_data", out_data, 32'hDEADBEEF);
    check("t1_err", err, 0);
    // back-to-back streaming
    sel = 5'b00001; in_valid = 5'b00001;
    for (int i = 1; i <= 3; i++) begin
      set_ch(0, W'(i));
      tick();
      check("stream_valid", out_valid, 1);
      check("stream_data", out_data, i);
    end
    in_valid = '0;
    tick();
    check("drain_valid", out_valid, 0);
    // backpressure
    set_ch(0, 32'hA5); in_valid = 5'b00001;
    tick();
    check("bp_first", out_data, 32'hA5);
    out_ready = 0; sel = 5'b00010; in_valid = 5'b00010; set_ch(1, 32'h5A); set_ch(0, 32'h99);
    #1 check("bp_ready0", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_data", out_data, 32'hA5);
      check("bp_hold_valid", out_valid, 1);
    end
    out_ready = 1;
    #1 check("bp_ready1", in_ready, 5'b00010);
    tick();
    check("bp_next_data", out_data, 32'h5A);
    check("bp_next_valid", out_valid, 1);
    in_valid = '0;
    tick();
    check("bp_drain", out_valid, 0);
    // multi-hot select
    sel = 5'b01010; in_valid = 5'b00010;
    #1 check("multi_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("multi_err", err, 1);
      check("multi_valid", out_valid, 0);
    end
    check("multi_sticky", err_sticky, 1);
    check("multi_cnt", err_cnt, 3);
    in_valid = '0;
    tick();
    check("multi_idle_err", err, 0);
    tick();
    check("multi_idle_err2", err, 0);
    check("multi_idle_cnt", err_cnt, 3);
    // clear, then saturate at 3
    err_clr = 1;
    tick();
    check("clr_cnt", err_cnt, 0);
    check("clr_sticky", err_sticky, 0);
    err_clr = 0; in_valid = 5'b00010;
    for (int i = 0; i < 5; i++) tick();
    check("sat_cnt", err_cnt, 3);
    err_clr = 1;
    tick();
    check("clrpri_cnt", err_cnt, 0);
    check("clrpri_sticky", err_sticky, 0);
    check("clrpri_err", err, 1);
    err_clr = 0; in_valid = '0;
    tick();
    check("post_clr_err", err, 0);
    check("post_clr_cnt", err_cnt, 0);
    // zero select
    sel = '0; in_valid = 5'b11111;
    #1 check("zero_ready", in_ready, 0);
    tick();
    check("zero_valid", out_valid, 0);
    check("zero_err", err, ZERR);
    check("zero_cnt", err_cnt, ZERR ? 1 : 0);
    in_valid = '0;
    // async reset while holding
    sel = 5'b00001; in_valid = 5'b00001; set_ch(0, 32'h77);
    tick();
    out_ready = 0; in_valid = '0;
    tick();
    check("hold_valid", out_valid, 1);
    check("hold_data", out_data, 32'h77);
    #2 rst_n = 0;
    #1 check("arst_valid", out_valid, 0);
    check("arst_data", out_data, 0);
    @(negedge clk) rst_n = 1;
    tick();
    check("arst_after", out_valid, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
